mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter directly downstream of the instruction and data caches. Accepts word requests from the icache (read) and dcache (read or write-back), serialises them onto the one RAM port, and returns data/wait to the winning cache. Data requests normally have priority. A starvation guard prevents the icache from being locked out, and a watchdog recovers from a RAM that never answers.

## Interface
- `TIMEOUT`, default 255: number of busy cycles without ACCESS before the transaction is aborted.
- `STARVE_MAX`, default 4: number of consecutive dcache grants, with iREN pending, before the icache is forced to win.
- `CLK` in 1: the single clock.
- `RST` in 1: synchronous, active-high reset.
- `iREN` in 1: icache read request.
- `iaddr` in 32: icache word address.
- `dREN` in 1: dcache read request.
- `dWEN` in 1: dcache write request.
- `daddr` in 32: dcache word address.
- `dstore` in 32: dcache write data.
- `iwait` out 1: low for exactly one cycle when the icache transaction completes.
- `dwait` out 1: low for exactly one cycle when the dcache transaction completes.
- `iload` out 32: icache read data, valid while iwait is low.
- `dload` out 32: dcache read data, valid while dwait is low.
- `ramREN` out 1: RAM read enable.
- `ramWEN` out 1: RAM write enable.
- `ramaddr` out 32: RAM address.
- `ramstore` out 32: RAM write data.
- `ramload` in 32: RAM read data.
- `ramstate` in 2: RAM status, ramstate_t (FREE, BUSY, ACCESS, ERROR).
- `arb_err` out 1: one-cycle pulse when a transaction is aborted.

## Operation
- States: IDLE, IRD, DRD, DWR.
- Arbitration happens in IDLE only.
  - Priority order: dWEN, then dREN, then iREN.
  - If starve_cnt == STARVE_MAX and iREN is high, the icache wins instead.
- Winning request is latched into addr_q and data_q. Next state is DWR, DRD or IRD.
- dWEN and dREN high together: treated as a write. dREN is ignored for that grant.
- In a busy state:
  - RAM outputs are driven only from the latched registers.
  - ramREN is high in IRD and DRD; ramWEN is high in DWR; never both.
  - ramstore = data_q in DWR, 0 otherwise.
- ramstate == ACCESS in a busy state:
  - The owner's wait goes low combinationally that same cycle.
  - The owner's load is driven as ramload (DRD/IRD); dload is 0 for DWR.
  - Next state is IDLE.
- ramstate == ERROR, or busy counter reaches TIMEOUT:
  - Owner's wait goes low with load = 32'hBAD1BAD1.
  - arb_err pulses; next state is IDLE.
- starve_cnt:
  - +1 on each dcache grant while iREN is high, saturating at STARVE_MAX.
  - Cleared on an icache grant, or on any grant where iREN is low.
- A requester that drops its request mid-transaction does not abort it. The transaction completes and its result is discarded.
- Non-owner wait stays high whenever its request is high. Wait for an idle (not requesting) cache is 1.

## Timing
- Cycle 0: request seen in IDLE. Cycle 1: RAM enable asserted. The earliest completion is cycle 1, so minimum latency is 2 cycles from request to wait low.
- One idle cycle always separates transactions. Back-to-back throughput is therefore 1 word per 2+RAM cycles.
- Busy counter behaviour:
  - Cleared on entry to a busy state.
  - Increments each busy cycle without ACCESS.
  - 8-bit, compared with `==` against TIMEOUT.
- Reset values (RST sampled high at the clock edge):
  - state = IDLE; ramREN = ramWEN = 0; ramaddr = ramstore = 0.
  - iwait = dwait = 1; iload = dload = 0; arb_err = 0.
  - starve_cnt and the busy counter = 0.
- Reset mid-transaction aborts silently. No arb_err, and RAM enables drop the cycle after the reset edge.
- A new request arriving in the same cycle as a completion is not granted until the following IDLE cycle.

## Structure
- The following go in diaosi_types_pkg:
  - arb_state_t enum (IDLE, IRD, DRD, DWR).
  - The BAD_WORD constant 32'hBAD1BAD1.
- ramstate_t and word_t come from cpu_types_pkg.
- One sub-module, `sat_counter` (parameter width and max; ports clear, inc, count, at_max), is instantiated twice: once for starve_cnt and once for the busy counter.

## Test plan
- iREN=1, iaddr=0x40, RAM ACCESS in cycle 2 with ramload=0x1234 -> ramREN=1 and ramaddr=0x40 from cycle 1; iwait=0 and iload=0x1234 in cycle 2 only; IDLE in cycle 3.
- iREN and dREN both high, continuously for 5 transactions -> grants are D,D,D,D,I.
  - starve_cnt reaches 4; the fifth grant goes to the icache, then the count clears.
- dWEN=dREN=1, daddr=0x80, dstore=0xCAFE -> ramWEN=1, ramREN=0, ramstore=0xCAFE; dwait=0 on ACCESS; dload=0.
- RAM held BUSY for 255 cycles on a dREN -> dwait=0, dload=0xBAD1BAD1 and arb_err=1 for one cycle, then IDLE. Repeat with ramstate=ERROR and expect the same response.
- RST asserted in the 3rd busy cycle of a DRD -> next cycle ramREN=0, dwait=1, arb_err=0, state=IDLE; a dREN held high is re-granted after reset releases.

Source files
------------

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared CPU-level types. Provides the machine word type and
//               the RAM status encoding reported by the memory model.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // RAM status as seen on the ramstate input.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage : cpu_types_pkg
`default_nettype wire

// File: rtl/diaosi_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : diaosi_types_pkg
// Description : Types and constants for the memory arbiter: the arbiter FSM
//               state encoding and the word returned on an aborted access.
// Revision    : 1.0 - initial release
// ============================================================================
package diaosi_types_pkg;

  import cpu_types_pkg::*;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IRD  = 2'd1,
    DRD  = 2'd2,
    DWR  = 2'd3
  } arb_state_t;

  // Returned to the owner when its transaction is aborted.
  localparam word_t BAD_WORD = 32'hBAD1BAD1;

endpackage : diaosi_types_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that saturates at MAX. clear has priority over inc.
//   clk    in  : clock
//   rst    in  : synchronous active-high reset (count -> 0)
//   clear  in  : synchronous clear (count -> 0)
//   inc    in  : increment by one unless already at MAX
//   count  out : current value
//   at_max out : count == MAX
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 8,
  parameter int MAX   = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX);

  assign at_max = (count == C_MAX);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + 1'b1;
    end
  end

endmodule : sat_counter
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Serialises icache reads and dcache reads/writes onto a single
//               RAM port. Data side has priority; after STARVE_MAX consecutive
//               dcache grants with the icache waiting, the icache is forced
//               through. A busy watchdog aborts a transaction the RAM never
//               answers.
//   CLK, RST             : clock, synchronous active-high reset
//   iREN, iaddr          : icache read request
//   dREN, dWEN, daddr,
//   dstore               : dcache read / write request
//   iwait/iload,
//   dwait/dload          : per-cache completion (wait low one cycle) + data
//   ramREN, ramWEN,
//   ramaddr, ramstore    : RAM command outputs
//   ramload, ramstate    : RAM response inputs
//   arb_err              : one-cycle pulse when a transaction is aborted
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import cpu_types_pkg::*;
  import diaosi_types_pkg::*;
#(
  parameter int TIMEOUT    = 255,
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        arb_err
);

  arb_state_t state, next_state;
  word_t      addr_q, data_q;
  word_t      addr_d, data_d;

  ramstate_t  rs;
  logic       busy;
  logic       access;
  logic       abort;
  logic       finish;
  logic       grant;
  logic       grant_i;

  logic [7:0] starve_cnt;
  logic       starve_full;
  logic [7:0] busy_cnt;
  logic       busy_timeout;

  assign rs     = ramstate_t'(ramstate);
  assign busy   = (state != IDLE);
  assign access = busy && (rs == ACCESS);
  // ACCESS wins over a coincident timeout: the data is good, keep it.
  assign abort  = busy && !access && ((rs == ERROR) || busy_timeout);
  assign finish = access || abort;

  assign grant   = (state == IDLE) && (next_state != IDLE);
  assign grant_i = grant && (next_state == IRD);

  // Next-state and grant selection.
  always_comb begin
    next_state = state;
    addr_d     = addr_q;
    data_d     = data_q;
    case (state)
      IDLE: begin
        if (starve_full && iREN) begin
          next_state = IRD;
          addr_d     = iaddr;
          data_d     = '0;
        end else if (dWEN) begin
          // dREN alongside dWEN is ignored: the grant is a write.
          next_state = DWR;
          addr_d     = daddr;
          data_d     = dstore;
        end else if (dREN) begin
          next_state = DRD;
          addr_d     = daddr;
          data_d     = '0;
        end else if (iREN) begin
          next_state = IRD;
          addr_d     = iaddr;
          data_d     = '0;
        end
      end
      IRD, DRD, DWR: begin
        if (finish) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // RAM-side and cache-side outputs. A requester that has dropped its
  // request sees wait=1 and load=0 even if its transaction completes.
  always_comb begin
    ramREN   = (state == IRD) || (state == DRD);
    ramWEN   = (state == DWR);
    ramaddr  = busy ? addr_q : '0;
    ramstore = (state == DWR) ? data_q : '0;
    arb_err  = abort;

    iwait = !(finish && (state == IRD) && iREN);
    dwait = !(finish && ((state == DRD) || (state == DWR)) && (dREN || dWEN));

    iload = '0;
    if (!iwait) begin
      iload = abort ? BAD_WORD : ramload;
    end

    dload = '0;
    if (!dwait) begin
      if (abort) begin
        dload = BAD_WORD;
      end else if (state == DRD) begin
        dload = ramload;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state <= next_state;
      if (grant) begin
        addr_q <= addr_d;
        data_q <= data_d;
      end
    end
  end

  // Consecutive dcache grants while the icache waits.
  sat_counter #(
    .WIDTH (8),
    .MAX   (STARVE_MAX)
  ) u_starve_cnt (
    .clk    (CLK),
    .rst    (RST),
    .clear  (grant_i || (grant && !iREN)),
    .inc    (grant && !grant_i && iREN),
    .count  (starve_cnt),
    .at_max (starve_full)
  );

  // Busy cycles without ACCESS; held at zero while idle so it starts from
  // zero on every entry to a busy state.
  sat_counter #(
    .WIDTH (8),
    .MAX   (TIMEOUT)
  ) u_busy_cnt (
    .clk    (CLK),
    .rst    (RST),
    .clear  (!busy),
    .inc    (busy && !access),
    .count  (busy_cnt),
    .at_max (busy_timeout)
  );

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter: directed vector table,
//               hand-written corner sequences, randomized run against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int          TIMEOUT    = 255;
  localparam int          STARVE_MAX = 4;
  localparam logic [1:0]  RS_FREE    = 2'd0;
  localparam logic [1:0]  RS_BUSY    = 2'd1;
  localparam logic [1:0]  RS_ACCESS  = 2'd2;
  localparam logic [1:0]  RS_ERROR   = 2'd3;
  localparam logic [31:0] BAD        = 32'hBAD1BAD1;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, arb_err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .arb_err(arb_err)
  );

  typedef struct {
    logic        iren, dren, dwen;
    logic [31:0] ia, da, ds;
    logic [1:0]  rs;
    logic [31:0] rl;
    logic        e_iw, e_dw;
    logic [31:0] e_il, e_dl;
    logic        e_ren, e_wen;
    logic [31:0] e_addr, e_st;
    logic        e_err;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(
    input logic ir, input logic dr, input logic dw,
    input logic [31:0] ia, input logic [31:0] da, input logic [31:0] ds,
    input logic [1:0] rs, input logic [31:0] rl,
    input logic iw, input logic dwt, input logic [31:0] il, input logic [31:0] dl,
    input logic ren, input logic wen, input logic [31:0] ad, input logic [31:0] st,
    input logic er);
    vec_t v;
    v.iren = ir; v.dren = dr; v.dwen = dw; v.ia = ia; v.da = da; v.ds = ds;
    v.rs = rs; v.rl = rl; v.e_iw = iw; v.e_dw = dwt; v.e_il = il; v.e_dl = dl;
    v.e_ren = ren; v.e_wen = wen; v.e_addr = ad; v.e_st = st; v.e_err = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ir, input logic dr, input logic dw,
                       input logic [31:0] ia, input logic [31:0] da,
                       input logic [31:0] ds, input logic [1:0] rs,
                       input logic [31:0] rl);
    iREN = ir; dREN = dr; dWEN = dw; iaddr = ia; daddr = da; dstore = ds;
    ramstate = rs; ramload = rl;
  endtask

  // Inputs are driven just after a falling edge; outputs sampled 2ns later.
  task automatic next_cycle();
    @(negedge CLK);
  endtask

  // Reference model: one outstanding transaction at most.
  int          m_busy, m_kind;   // kind: 0 icache read, 1 dcache read, 2 dcache write
  logic [31:0] m_addr, m_data;
  int          m_age, m_starve;

  logic [31:0] grants[$];

  initial begin
    tbl[0]  = mk(1,0,0, 32'h40,0,0,            RS_FREE,  0,        1,1,0,0,            0,0,0,0,0);
    tbl[1]  = mk(1,0,0, 32'h40,0,0,            RS_BUSY,  0,        1,1,0,0,            1,0,32'h40,0,0);
    tbl[2]  = mk(1,0,0, 32'h40,0,0,            RS_ACCESS,32'h1234, 0,1,32'h1234,0,     1,0,32'h40,0,0);
    tbl[3]  = mk(0,0,0, 0,0,0,                 RS_FREE,  0,        1,1,0,0,            0,0,0,0,0);
    tbl[4]  = mk(0,1,1, 0,32'h80,32'hCAFE,     RS_FREE,  0,        1,1,0,0,            0,0,0,0,0);
    tbl[5]  = mk(0,1,1, 0,32'h80,32'hCAFE,     RS_ACCESS,32'h5555, 1,0,0,0,            0,1,32'h80,32'hCAFE,0);
    tbl[6]  = mk(0,0,0, 0,0,0,                 RS_FREE,  0,        1,1,0,0,            0,0,0,0,0);
    tbl[7]  = mk(0,1,0, 0,32'h90,0,            RS_FREE,  0,        1,1,0,0,            0,0,0,0,0);
    tbl[8]  = mk(0,1,0, 0,32'h90,0,            RS_ERROR, 0,        1,0,0,BAD,          1,0,32'h90,0,1);
    tbl[9]  = mk(0,0,0, 0,0,0,                 RS_FREE,  0,        1,1,0,0,            0,0,0,0,0);
    tbl[10] = mk(1,1,0, 32'h44,32'h94,0,       RS_FREE,  0,        1,1,0,0,            0,0,0,0,0);
    tbl[11] = mk(1,1,0, 32'h44,32'h94,0,       RS_ACCESS,32'h77,   1,0,0,32'h77,       1,0,32'h94,0,0);
    tbl[12] = mk(1,0,0, 32'h44,32'h94,0,       RS_FREE,  0,        1,1,0,0,            0,0,0,0,0);
    tbl[13] = mk(1,0,0, 32'h44,32'h94,0,       RS_ACCESS,32'h88,   0,1,32'h88,0,       1,0,32'h44,0,0);
    tbl[14] = mk(0,0,0, 0,0,0,                 RS_FREE,  0,        1,1,0,0,            0,0,0,0,0);

    // ---------------- reset state ----------------
    RST = 1'b1;
    drive(0,0,0,0,0,0,RS_FREE,0);
    repeat (2) @(posedge CLK);
    next_cycle();
    drive(1,1,1,32'h11,32'h22,32'h33,RS_ACCESS,32'h44);
    #2;
    chk("reset_ramREN",   {31'd0, ramREN}, 0);
    chk("reset_ramWEN",   {31'd0, ramWEN}, 0);
    chk("reset_ramaddr",  ramaddr, 0);
    chk("reset_ramstore", ramstore, 0);
    chk("reset_iwait",    {31'd0, iwait}, 1);
    chk("reset_dwait",    {31'd0, dwait}, 1);
    chk("reset_iload",    iload, 0);
    chk("reset_dload",    dload, 0);
    chk("reset_arb_err",  {31'd0, arb_err}, 0);
    next_cycle();
    drive(0,0,0,0,0,0,RS_FREE,0);
    RST = 1'b0;
    #2;

    // ---------------- vector table ----------------
    for (int i = 0; i < 15; i++) begin
      next_cycle();
      drive(tbl[i].iren, tbl[i].dren, tbl[i].dwen, tbl[i].ia, tbl[i].da,
            tbl[i].ds, tbl[i].rs, tbl[i].rl);
      #2;
      chk($sformatf("v%0d_iwait", i),    {31'd0, iwait},  {31'd0, tbl[i].e_iw});
      chk($sformatf("v%0d_dwait", i),    {31'd0, dwait},  {31'd0, tbl[i].e_dw});
      chk($sformatf("v%0d_iload", i),    iload,           tbl[i].e_il);
      chk($sformatf("v%0d_dload", i),    dload,           tbl[i].e_dl);
      chk($sformatf("v%0d_ramREN", i),   {31'd0, ramREN}, {31'd0, tbl[i].e_ren});
      chk($sformatf("v%0d_ramWEN", i),   {31'd0, ramWEN}, {31'd0, tbl[i].e_wen});
      chk($sformatf("v%0d_ramaddr", i),  ramaddr,         tbl[i].e_addr);
      chk($sformatf("v%0d_ramstore", i), ramstore,        tbl[i].e_st);
      chk($sformatf("v%0d_arb_err", i),  {31'd0, arb_err},{31'd0, tbl[i].e_err});
    end

    // ---------------- starvation: D,D,D,D,I then D ----------------
    // Each transaction is one idle cycle plus one busy cycle with ACCESS.
    for (int t = 0; t < 6; t++) begin
      next_cycle();
      drive(1,1,0,32'h100,32'h200,0,RS_FREE,0);
      next_cycle();
      drive(1,1,0,32'h100,32'h200,0,RS_ACCESS,32'h1000 + t);
      #2;
      chk($sformatf("starve_t%0d_ramREN", t), {31'd0, ramREN}, 1);
      grants.push_back(ramaddr);
    end
    for (int t = 0; t < 6; t++) begin
      chk($sformatf("starve_grant%0d", t), grants[t],
          (t == 4) ? 32'h100 : 32'h200);
    end

    // ---------------- watchdog timeout on a dcache read ----------------
    begin
      int n;
      int early_err;
      logic seen;
      n = 0; early_err = 0; seen = 1'b0;
      next_cycle();
      drive(0,1,0,0,32'hA0,0,RS_FREE,0);
      for (int c = 1; c <= 300; c++) begin
        next_cycle();
        drive(0,1,0,0,32'hA0,0,RS_BUSY,32'h5A5A);
        #2;
        if (!dwait) begin
          n = c; seen = 1'b1;
          chk("timeout_dload", dload, BAD);
          chk("timeout_err",   {31'd0, arb_err}, 1);
          break;
        end
        if (arb_err) early_err++;
      end
      chk("timeout_seen",   {31'd0, seen}, 1);
      chk("timeout_cycles", n, TIMEOUT + 1);
      chk("timeout_no_early_err", early_err, 0);
      next_cycle();
      drive(0,0,0,0,0,0,RS_BUSY,0);
      #2;
      chk("timeout_idle_ren", {31'd0, ramREN}, 0);
      chk("timeout_idle_err", {31'd0, arb_err}, 0);
    end

    // ---------------- ERROR response ----------------
    next_cycle();
    drive(0,1,0,0,32'hA4,0,RS_FREE,0);
    next_cycle();
    drive(0,1,0,0,32'hA4,0,RS_ERROR,32'h1111);
    #2;
    chk("error_dwait", {31'd0, dwait}, 0);
    chk("error_dload", dload, BAD);
    chk("error_err",   {31'd0, arb_err}, 1);
    next_cycle();
    drive(0,0,0,0,0,0,RS_FREE,0);
    #2;
    chk("error_idle_ren", {31'd0, ramREN}, 0);
    chk("error_idle_err", {31'd0, arb_err}, 0);

    // ---------------- reset in 3rd busy cycle of a DRD ----------------
    next_cycle();
    drive(0,1,0,0,32'hB0,0,RS_FREE,0);
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      drive(0,1,0,0,32'hB0,0,RS_BUSY,0);
      if (c == 3) RST = 1'b1;
      #2;
      chk($sformatf("rstmid_busy%0d_ren", c), {31'd0, ramREN}, 1);
    end
    next_cycle();
    RST = 1'b0;
    #2;
    chk("rstmid_ren",   {31'd0, ramREN}, 0);
    chk("rstmid_dwait", {31'd0, dwait}, 1);
    chk("rstmid_err",   {31'd0, arb_err}, 0);
    chk("rstmid_addr",  ramaddr, 0);
    next_cycle();
    drive(0,1,0,0,32'hB0,0,RS_ACCESS,32'hD00D);
    #2;
    chk("rstmid_regrant_ren",  {31'd0, ramREN}, 1);
    chk("rstmid_regrant_addr", ramaddr, 32'hB0);
    chk("rstmid_regrant_dload", dload, 32'hD00D);

    // ---------------- randomized run vs reference model ----------------
    next_cycle();
    RST = 1'b1;
    drive(0,0,0,0,0,0,RS_FREE,0);
    @(posedge CLK);
    m_busy = 0; m_kind = 0; m_addr = 0; m_data = 0; m_age = 0; m_starve = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        e_iw, e_dw, e_ren, e_wen, e_err, done, abrt;
      logic [31:0] e_il, e_dl, e_addr, e_st;
      int          pick;
      next_cycle();
      RST = ($urandom_range(0, 249) == 0);
      iREN = ($urandom_range(0, 3) != 0);
      dREN = ($urandom_range(0, 2) == 0);
      dWEN = ($urandom_range(0, 3) == 0);
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      pick = $urandom_range(0, 9);
      ramstate = (pick < 5) ? RS_ACCESS : (pick == 5) ? RS_ERROR :
                 (pick < 8) ? RS_BUSY : RS_FREE;
      #2;
      // Expected outputs from the current transaction and this cycle's inputs.
      e_iw = 1; e_dw = 1; e_il = 0; e_dl = 0; e_ren = 0; e_wen = 0;
      e_addr = 0; e_st = 0; e_err = 0; done = 0; abrt = 0;
      if (m_busy != 0) begin
        e_ren  = (m_kind != 2);
        e_wen  = (m_kind == 2);
        e_addr = m_addr;
        e_st   = (m_kind == 2) ? m_data : 0;
        done   = (ramstate == RS_ACCESS);
        abrt   = !done && (ramstate == RS_ERROR || m_age >= TIMEOUT);
        e_err  = abrt;
        if (done || abrt) begin
          if (m_kind == 0 && iREN) begin
            e_iw = 0; e_il = abrt ? BAD : ramload;
          end
          if (m_kind != 0 && (dREN || dWEN)) begin
            e_dw = 0; e_dl = abrt ? BAD : (m_kind == 1) ? ramload : 0;
          end
        end
      end
      chk("rnd_iwait",    {31'd0, iwait},  {31'd0, e_iw});
      chk("rnd_dwait",    {31'd0, dwait},  {31'd0, e_dw});
      chk("rnd_iload",    iload,           e_il);
      chk("rnd_dload",    dload,           e_dl);
      chk("rnd_ramREN",   {31'd0, ramREN}, {31'd0, e_ren});
      chk("rnd_ramWEN",   {31'd0, ramWEN}, {31'd0, e_wen});
      chk("rnd_ramaddr",  ramaddr,         e_addr);
      chk("rnd_ramstore", ramstore,        e_st);
      chk("rnd_arb_err",  {31'd0, arb_err},{31'd0, e_err});
      @(posedge CLK);
      // Advance the model across the edge.
      if (RST) begin
        m_busy = 0; m_starve = 0; m_age = 0;
      end else if (m_busy == 0) begin
        if (iREN || dREN || dWEN) begin
          if (iREN && m_starve == STARVE_MAX) m_kind = 0;
          else if (dWEN)                      m_kind = 2;
          else if (dREN)                      m_kind = 1;
          else                                m_kind = 0;
          m_addr = (m_kind == 0) ? iaddr : daddr;
          m_data = dstore;
          if (m_kind == 0 || !iREN) m_starve = 0;
          else if (m_starve < STARVE_MAX) m_starve = m_starve + 1;
          m_busy = 1; m_age = 0;
        end
      end else if (done || abrt) begin
        m_busy = 0;
      end else begin
        m_age = m_age + 1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

endmodule : tb_mem_arbiter
`default_nettype wire
